// File: rtl/prio_encoder_seq_if.sv
// Request/grant bundle for prio_encoder_seq: request inputs, granted code and pending set.
// ENC_SEG7_EN adds the active-low seven-segment view of the granted code.
interface prio_encoder_seq_if #(parameter int N = 8);
    localparam int W = $clog2(N);

    logic         en;
    logic [N-1:0] x;
    logic         y_ready;
    logic [W-1:0] y;
    logic         y_valid;
    logic [N-1:0] pending;
`ifdef ENC_SEG7_EN
    logic [6:0]   seg;

    modport master (output en, x, y_ready, input y, y_valid, pending, seg);
    modport slave  (input en, x, y_ready, output y, y_valid, pending, seg);
`else
    modport master (output en, x, y_ready, input y, y_valid, pending);
    modport slave  (input en, x, y_ready, output y, y_valid, pending);
`endif
endinterface

// File: rtl/prio_encoder_seq.sv
// Sequential priority encoder: sticky pending requests drain highest-index first over valid/ready.
// ENC_SEG7_EN adds a registered active-low hex seven-segment output (a..g = seg[0..6]).
module prio_encoder_seq #(
    parameter int N = 8
) (
    input logic               clk,
    input logic               rst_n,
    prio_encoder_seq_if.slave bus
);
    localparam int W = $clog2(N);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] y_q, y_d;
    logic [N-1:0] pending_q, pending_d;
    logic [N-1:0] set_bits, clr_bits;
    logic [W-1:0] sel;
    logic         ack;

    always_comb begin
        ack      = (state_q == HOLD) && bus.y_ready;
        set_bits = bus.en ? bus.x : '0;
        clr_bits = '0;
        if (ack) clr_bits[y_q] = 1'b1;
        // set is OR-ed after the clear so a re-request of the acked bit survives
        pending_d = (pending_q & ~clr_bits) | set_bits;

        sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (pending_d[i]) sel = W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        unique case (state_q)
            IDLE: begin
                if (|pending_d) begin
                    y_d     = sel;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.y_ready) begin
                    if (|pending_d) begin
                        y_d = sel;
                    end else begin
                        y_d     = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                y_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            y_q       <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            pending_q <= pending_d;
        end
    end

    assign bus.y       = y_q;
    assign bus.y_valid = (state_q == HOLD);
    assign bus.pending = pending_q;

`ifdef ENC_SEG7_EN
    logic [6:0] seg_q, seg_d;

    function automatic logic [6:0] hex7_n(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // decoded from the next-state values so seg updates on the same edge as y
    always_comb begin
        seg_d = 7'h7F;
        if (state_d == HOLD) seg_d = hex7_n(4'(y_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seg_q <= 7'h7F;
        else        seg_q <= seg_d;
    end

    assign bus.seg = seg_q;
`endif
endmodule

// File: tb/tb_prio_encoder_seq.sv
// Scoreboard bench for prio_encoder_seq (N=8): directed scenarios plus randomized traffic.
module tb_prio_encoder_seq;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    prio_encoder_seq_if #(.N(8)) bus ();
    prio_encoder_seq #(.N(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic       v;
        logic [2:0] y;
        logic [7:0] p;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // reference state: what the outputs should be after the most recent edge
    logic       m_valid;
    logic [2:0] m_y;
    logic [7:0] m_pend;

    logic [6:0] seg_on [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int highest(input logic [7:0] p);
        for (int i = 7; i >= 0; i--) if (p[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_y     = '0;
        m_pend  = '0;
    endtask

    task automatic model_step(input logic en, input logic [7:0] x, input logic rdy);
        logic [7:0] p;
        logic       took;
        took = m_valid && rdy;
        p    = m_pend;
        if (took) p[m_y] = 1'b0;
        if (en) p = p | x;
        if (!m_valid || took) begin
            if (p != 0) begin
                m_valid = 1'b1;
                m_y     = 3'(highest(p));
            end else begin
                m_valid = 1'b0;
                m_y     = '0;
            end
        end
        m_pend = p;
    endtask

    // called at posedge+1: drive, take the edge, predict, queue expectation
    task automatic cycle(input logic en, input logic [7:0] x, input logic rdy);
        exp_t e;
        bus.en      = en;
        bus.x       = x;
        bus.y_ready = rdy;
        @(posedge clk);
        model_step(en, x, rdy);
        e.v = m_valid;
        e.y = m_y;
        e.p = m_pend;
        sb.push_back(e);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_valid", int'(bus.y_valid), int'(e.v));
            chk("sb_pending", int'(bus.pending), int'(e.p));
            if (e.v) chk("sb_y", int'(bus.y), int'(e.y));
`ifdef ENC_SEG7_EN
            chk("sb_seg", int'(bus.seg), e.v ? int'(~seg_on[e.y]) : 7'h7F);
`endif
        end
    end

    initial begin
        rst_n       = 1'b0;
        bus.en      = 1'b0;
        bus.x       = '0;
        bus.y_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", int'(bus.y_valid), 0);
        chk("rst_y", int'(bus.y), 0);
        chk("rst_pending", int'(bus.pending), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // single request held while downstream stalls
        cycle(1'b1, 8'h10, 1'b0);
        chk("single_y", int'(bus.y), 4);
        chk("single_valid", int'(bus.y_valid), 1);
`ifdef ENC_SEG7_EN
        chk("seg_4", int'(bus.seg), 7'b0011001);
`endif
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'h00, 1'b0);
            chk("single_hold", int'(bus.y), 4);
        end
        cycle(1'b0, 8'h00, 1'b1);
        chk("single_done", int'(bus.y_valid), 0);
`ifdef ENC_SEG7_EN
        chk("seg_off", int'(bus.seg), 7'h7F);
`endif

        // back-to-back priority drain
        cycle(1'b1, 8'h85, 1'b1);
        chk("drain_7", int'(bus.y), 7);
        cycle(1'b0, 8'h00, 1'b1);
        chk("drain_2", int'(bus.y), 2);
        cycle(1'b0, 8'h00, 1'b1);
        chk("drain_0", int'(bus.y), 0);
        chk("drain_0_valid", int'(bus.y_valid), 1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("drain_end", int'(bus.y_valid), 0);

        // no preemption by a higher request while stalled
        cycle(1'b1, 8'h04, 1'b0);
        cycle(1'b1, 8'h40, 1'b0);
        chk("nopre_y", int'(bus.y), 2);
        cycle(1'b0, 8'h00, 1'b1);
        chk("nopre_next", int'(bus.y), 6);
        cycle(1'b0, 8'h00, 1'b1);

        // re-request of the bit being acked is served again
        cycle(1'b1, 8'h08, 1'b0);
        cycle(1'b1, 8'h08, 1'b1);
        chk("setclr_valid", int'(bus.y_valid), 1);
        chk("setclr_y", int'(bus.y), 3);
        cycle(1'b0, 8'h00, 1'b1);
        chk("setclr_end", int'(bus.y_valid), 0);

        // disabled input is ignored
        cycle(1'b0, 8'hFF, 1'b0);
        chk("en_pending", int'(bus.pending), 0);
        chk("en_valid", int'(bus.y_valid), 0);

        // asynchronous reset in the middle of a hold
        cycle(1'b1, 8'h30, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(bus.y_valid), 0);
        chk("arst_y", int'(bus.y), 0);
        chk("arst_pending", int'(bus.pending), 0);
`ifdef ENC_SEG7_EN
        chk("arst_seg", int'(bus.seg), 7'h7F);
`endif
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            logic [7:0] rx;
            rx = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            cycle(1'($urandom_range(0, 4) != 0), rx, 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("drain_all", int'(bus.y_valid), 0);

        @(negedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
